// File: rtl/mem_if_pkg.sv
// Shared types and constants for the CPU-side memory responders.
// Holds the responder FSM encoding and the word/lane geometry.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam int CNT_W  = 4;
    localparam int WORD_W = 32;
    localparam int LANE_W = 8;
    localparam int LANES  = WORD_W / LANE_W;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-enable merge of a store word into an existing memory word.
// Lanes with a clear enable keep the old byte.
module byte_lane_merge
    import mem_if_pkg::*;
(
    input  logic [WORD_W-1:0] old_word_i,
    input  logic [WORD_W-1:0] new_word_i,
    input  logic [LANES-1:0]  be_i,
    output logic [WORD_W-1:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int i = 0; i < LANES; i++) begin
            if (be_i[i]) begin
                merged_o[i*LANE_W +: LANE_W] = new_word_i[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port RAM responder: byte-enable writes, fixed-latency reads,
// combinational stall while a read is in flight, error pulse on bad requests.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int          ADDR_BITS    = 10,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [WORD_W-1:0] data_writedata,
    input  logic [LANES-1:0]  data_byteenable,
    output logic [WORD_W-1:0] data_readdata,
    output logic              data_valid,
    output logic              data_stall,
    output logic              data_error
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam bit LAT1  = (READ_LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]      rdata_q, rdata_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;

    logic [WORD_W-1:0]      mem_q [DEPTH];
    logic [WORD_W-1:0]      merged;
    logic [31:0]            offset;
    logic [ADDR_BITS-1:0]   idx;
    logic                   legal;
    logic                   idle;
    logic                   bad;
    logic                   wr_en;
    logic                   rd_acc;

    // BASE_ADDR is word aligned, so offset alignment equals address alignment
    assign offset = data_address - BASE_ADDR;
    assign legal  = (offset[1:0] == 2'b00) &&
                    (offset[31:ADDR_BITS+2] == '0);
    assign idx    = offset[ADDR_BITS+1:2];
    assign idle   = (state_q == IDLE);

    assign bad    = idle && (data_read || data_write) &&
                    ((data_read && data_write) || !legal);
    assign wr_en  = idle && data_write && !data_read && legal;
    assign rd_acc = idle && data_read && !data_write && legal;

    byte_lane_merge u_merge (
        .old_word_i (mem_q[idx]),
        .new_word_i (data_writedata),
        .be_i       (data_byteenable),
        .merged_o   (merged)
    );

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[idx] <= merged;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        error_d = bad;
        unique case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    if (LAT1) begin
                        rdata_d = mem_q[idx];
                        valid_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                        idx_d   = idx;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_q[idx_q];
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // RESP keeps stall low so the CPU advances on the edge that ends it
    assign data_stall    = (rd_acc && !LAT1) || (state_q == BUSY);
    assign data_readdata = rdata_q;
    assign data_valid    = valid_q;
    assign data_error    = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at read latencies 1, 2 and 4 in parallel.
// A transaction-level model predicts every output each cycle.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [3:0]  be;

    logic [31:0] rdq [3];
    logic        vq  [3];
    logic        sq  [3];
    logic        eq  [3];

    int tests = 0;
    int fails = 0;

    // model: memory image, edges left before idle, pending data, expected regs
    logic [31:0] mm   [3][1024];
    int          busy [3];
    logic [31:0] pend [3];
    logic [31:0] xr   [3];
    logic        xv   [3];
    logic        xe   [3];

    always #5 clk = ~clk;

    data_mem_responder #(.READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .data_address(addr),
        .data_read(rd), .data_write(wr), .data_writedata(wdata),
        .data_byteenable(be), .data_readdata(rdq[0]),
        .data_valid(vq[0]), .data_stall(sq[0]), .data_error(eq[0])
    );

    data_mem_responder #(.READ_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .data_address(addr),
        .data_read(rd), .data_write(wr), .data_writedata(wdata),
        .data_byteenable(be), .data_readdata(rdq[1]),
        .data_valid(vq[1]), .data_stall(sq[1]), .data_error(eq[1])
    );

    data_mem_responder #(.READ_LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .data_address(addr),
        .data_read(rd), .data_write(wr), .data_writedata(wdata),
        .data_byteenable(be), .data_readdata(rdq[2]),
        .data_valid(vq[2]), .data_stall(sq[2]), .data_error(eq[2])
    );

    function automatic int lat(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic logic legal_f(logic [31:0] a);
        logic [31:0] o;
        o = a - 32'h1000;
        return (a[1:0] == 2'b00) && (o < 32'd4096);
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            busy[k] = 0;
            xr[k]   = '0;
            xv[k]   = 1'b0;
            xe[k]   = 1'b0;
        end
    endtask

    task automatic check_regs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("valid_l%0d", lat(k)), 32'(vq[k]), 32'(xv[k]));
            chk($sformatf("error_l%0d", lat(k)), 32'(eq[k]), 32'(xe[k]));
            chk($sformatf("rdata_l%0d", lat(k)), rdq[k], xr[k]);
        end
    endtask

    // one clock edge of the transaction model
    task automatic model_step(logic r, logic w, logic [31:0] a,
                              logic [31:0] d, logic [3:0] b);
        int idx;
        for (int k = 0; k < 3; k++) begin
            xv[k] = 1'b0;
            xe[k] = 1'b0;
            if (busy[k] > 0) begin
                if (busy[k] == 2) begin
                    xv[k] = 1'b1;
                    xr[k] = pend[k];
                end
                busy[k]--;
            end else if (r || w) begin
                if ((r && w) || !legal_f(a)) begin
                    xe[k] = 1'b1;
                end else begin
                    idx = int'((a - 32'h1000) >> 2);
                    if (w) begin
                        for (int i = 0; i < 4; i++)
                            if (b[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
                    end else if (lat(k) == 1) begin
                        xv[k] = 1'b1;
                        xr[k] = mm[k][idx];
                    end else begin
                        pend[k] = mm[k][idx];
                        busy[k] = lat(k);
                    end
                end
            end
        end
    endtask

    task automatic cyc(logic r, logic w, logic [31:0] a,
                       logic [31:0] d, logic [3:0] b, logic rs);
        logic xs;
        @(negedge clk);
        check_regs();
        rd = r; wr = w; addr = a; wdata = d; be = b; reset = rs;
        #1;
        if (rs) begin
            model_reset();
            check_regs();
        end
        for (int k = 0; k < 3; k++) begin
            xs = !rs && (busy[k] >= 2 ||
                 (busy[k] == 0 && r && !w && legal_f(a) && lat(k) > 1));
            chk($sformatf("stall_l%0d", lat(k)), 32'(sq[k]), 32'(xs));
        end
        if (!rs) model_step(r, w, a, d, b);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        logic        r;
        logic        w;
        logic        rs;
        logic [31:0] a;
        int          sel;

        reset = 1'b1;
        rd = 0; wr = 0; addr = '0; wdata = '0; be = '0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", 32'(vq[k]), 32'd0);
            chk("reset_rdata", rdq[k], 32'd0);
            chk("reset_stall", 32'(sq[k]), 32'd0);
        end
        cyc(0, 0, '0, '0, '0, 1);
        idle(2);

        for (int i = 0; i < 16; i++)
            cyc(0, 1, 32'h1000 + 32'(4 * i),
                (i == 1) ? 32'h1122_3344 : (32'hA500_0000 | 32'(i)),
                4'hF, 0);

        // full-word write then latency-2 read
        cyc(0, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 0);
        cyc(1, 0, 32'h1000, '0, '0, 0);
        chk("lit_stall_l2_a", 32'(sq[1]), 32'd1);
        chk("lit_stall_l1_a", 32'(sq[0]), 32'd0);
        idle(1);
        chk("lit_valid_l1", 32'(vq[0]), 32'd1);
        chk("lit_rdata_l1", rdq[0], 32'hDEAD_BEEF);
        chk("lit_stall_l2_b", 32'(sq[1]), 32'd1);
        chk("lit_valid_l2_b", 32'(vq[1]), 32'd0);
        idle(1);
        chk("lit_valid_l2", 32'(vq[1]), 32'd1);
        chk("lit_rdata_l2", rdq[1], 32'hDEAD_BEEF);
        chk("lit_stall_l2_c", 32'(sq[1]), 32'd0);
        idle(6);

        // single-lane write over a preloaded word
        cyc(0, 1, 32'h1004, 32'h0000_00AA, 4'h1, 0);
        cyc(1, 0, 32'h1004, '0, '0, 0);
        idle(2);
        chk("lit_merge_l2", rdq[1], 32'h1122_33AA);
        idle(6);

        // misaligned and out-of-range reads
        cyc(1, 0, 32'h1002, '0, '0, 0);
        chk("lit_mis_stall", 32'(sq[1]), 32'd0);
        idle(1);
        chk("lit_mis_err", 32'(eq[1]), 32'd1);
        chk("lit_mis_rdata", rdq[1], 32'h1122_33AA);
        idle(1);
        chk("lit_err_pulse", 32'(eq[1]), 32'd0);
        cyc(1, 0, 32'h2000, '0, '0, 0);
        chk("lit_oor_stall", 32'(sq[2]), 32'd0);
        idle(1);
        chk("lit_oor_err", 32'(eq[2]), 32'd1);
        idle(4);

        // simultaneous read and write is rejected
        cyc(1, 1, 32'h1008, 32'hFFFF_FFFF, 4'hF, 0);
        idle(1);
        chk("lit_rw_err", 32'(eq[0]), 32'd1);
        idle(2);
        cyc(1, 0, 32'h1008, '0, '0, 0);
        idle(2);
        chk("lit_rw_old", rdq[1], 32'hA500_0002);
        idle(6);

        // reset while the latency-4 read is in flight
        cyc(1, 0, 32'h1000, '0, '0, 0);
        idle(1);
        chk("lit_busy_l4", 32'(sq[2]), 32'd1);
        cyc(0, 0, '0, '0, '0, 1);
        chk("lit_rst_stall", 32'(sq[2]), 32'd0);
        chk("lit_rst_valid", 32'(vq[2]), 32'd0);
        chk("lit_rst_rdata", rdq[2], 32'd0);
        idle(1);
        cyc(1, 0, 32'h1004, '0, '0, 0);
        idle(3);
        chk("lit_l4_early", 32'(vq[2]), 32'd0);
        idle(1);
        chk("lit_l4_valid", 32'(vq[2]), 32'd1);
        chk("lit_l4_rdata", rdq[2], 32'h1122_33AA);
        idle(6);

        // latency-1 back-to-back reads
        cyc(1, 0, 32'h1000, '0, '0, 0);
        chk("lit_b2b_stall0", 32'(sq[0]), 32'd0);
        cyc(1, 0, 32'h1004, '0, '0, 0);
        chk("lit_b2b_stall1", 32'(sq[0]), 32'd0);
        chk("lit_b2b_v0", 32'(vq[0]), 32'd1);
        chk("lit_b2b_d0", rdq[0], 32'hDEAD_BEEF);
        idle(1);
        chk("lit_b2b_v1", 32'(vq[0]), 32'd1);
        chk("lit_b2b_d1", rdq[0], 32'h1122_33AA);
        idle(6);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 19);
            a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            else if (sel == 2) a = 32'h0FFC;
            r  = ($urandom_range(0, 9) < 4);
            w  = ($urandom_range(0, 9) < 4);
            rs = ($urandom_range(0, 299) == 0);
            cyc(r, w, a, $urandom, 4'($urandom), rs);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Harvard-side data memory responder answering the CPU's data port: word-organised RAM with byte-enable writes and configurable read latency.
- Drives a stall signal so the CPU holds its clock enable low while a read is outstanding.
- Sits between the CPU data port and the testbench/top level, opposite the CPU's load/store initiator logic.

Parameters:
- ADDR_BITS, 10, log2 of memory depth in 32-bit words.
- BASE_ADDR, 32'h0000_1000, byte address of word 0; must be word aligned.
- READ_LATENCY, 2, clock edges from accepted read to data valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- data_address  in  32  byte address from the CPU.
- data_read  in  1  read request.
- data_write  in  1  write request.
- data_writedata  in  32  store data, little-endian lanes.
- data_byteenable  in  4  lane enables; bit i covers bits [8i+7:8i].
- data_readdata  out  32  load data, registered.
- data_valid  out  1  one-cycle pulse: data_readdata holds a fresh read result.
- data_stall  out  1  high means the CPU must hold clk_enable low.
- data_error  out  1  one-cycle pulse: a request was rejected.

Behaviour:
- Reset (async): state=IDLE, latency counter=0, data_readdata=0, data_valid=0, data_error=0. Memory array is NOT cleared.
- Address decode:
  - offset = data_address - BASE_ADDR.
  - Request is legal iff data_address[1:0]==0 and offset < 4*2^ADDR_BITS.
  - Word index = offset[ADDR_BITS+1:2].
- FSM states: IDLE, BUSY, RESP.
- IDLE, data_write only, legal: on the edge, lanes with byteenable=1 are written and the other lanes keep their value. No stall, no valid. byteenable=0 completes as a no-op.
- IDLE, data_read only, legal:
  - Index is latched on the edge.
  - READ_LATENCY=1: data_readdata is loaded from the array and data_valid=1 next cycle; state stays IDLE.
  - READ_LATENCY>1: state goes to BUSY, counter=READ_LATENCY-2.
- BUSY: counter decrements each edge. At counter==0, data_readdata is loaded from the latched index, data_valid=1, state goes to RESP.
- RESP: lasts one cycle, then returns to IDLE. A new request presented in RESP is ignored; the CPU re-presents it next cycle.
- data_stall is combinational:
  - high when (state==IDLE && data_read && legal && READ_LATENCY>1) || state==BUSY;
  - low in RESP, so the CPU advances on the edge ending RESP.
- Requests are sampled only in IDLE. Input changes during BUSY are ignored. The array is not written during BUSY or RESP.
- Errors, all evaluated in IDLE:
  - data_read && data_write together, illegal address, or misaligned address: neither access is performed, data_error pulses for one cycle, no stall, data_readdata is unchanged.
- Read-after-write: a read accepted the cycle after a write to the same word returns the merged new data.
- data_valid and data_error are never high in the same cycle.
- Reset asserted in BUSY aborts the read: no valid pulse, and stall drops immediately.

Decomposition:
- Shared package mem_if_pkg:
  - state enum (IDLE, BUSY, RESP);
  - latency counter width (4);
  - default BASE_ADDR constant;
  - word/lane width constants.
- One sub-module, byte_lane_merge: combinational; takes old word, new word and byteenable, returns the merged word. Reused by a future instruction-memory responder.

Test Plan:
- Write 32'hDEADBEEF at 32'h1000 with byteenable 4'hF, then read at 32'h1000 (latency 2) -> stall high 2 cycles, valid pulse in cycle 2, readdata=32'hDEADBEEF.
- Write 32'h000000AA at 32'h1004 with byteenable 4'h1 over preload 32'h11223344, then read -> 32'h112233AA.
- Read at 32'h1002 (misaligned) and at BASE+4*1024 (out of range) -> each gives a one-cycle error pulse, no stall, readdata unchanged.
- data_read and data_write both high at 32'h1008 -> error pulse; a later read of 32'h1008 returns its old value.
- Reset asserted during BUSY with READ_LATENCY=4 -> stall, valid and readdata go to 0 immediately; the next read completes normally after 4 edges.
- READ_LATENCY=1: back-to-back reads of 32'h1000 and 32'h1004 -> no stall, valid high on consecutive cycles with the correct data.
